// File: rtl/simple_proc_pkg.sv
// rtl/simple_proc_pkg.sv - shared constants and types for the simple processor control unit
//
// Purpose: opcode values, FSM state encoding, bus-select codes and field
// widths shared by the control unit, its interface and its decoder.
// Ports: none (package).

package simple_proc_pkg;

   localparam int IR_W     = 9;
   localparam int IDX_W    = 3;
   localparam int NUM_REGS = 8;
   localparam int SEL_W    = 4;

   localparam logic [2:0] OPC_MV  = 3'b000;
   localparam logic [2:0] OPC_MVI = 3'b001;
   localparam logic [2:0] OPC_ADD = 3'b010;
   localparam logic [2:0] OPC_SUB = 3'b011;

   localparam logic [SEL_W-1:0] SEL_G   = 4'd8;
   localparam logic [SEL_W-1:0] SEL_DIN = 4'd9;

   typedef enum logic [1:0] {
      ST_T0 = 2'd0,
      ST_T1 = 2'd1,
      ST_T2 = 2'd2,
      ST_T3 = 2'd3
   } state_t;

   // Bus codes 0..7 select R0..R7 directly, so a register index widens to a select code.
   function automatic logic [SEL_W-1:0] reg_sel(input logic [IDX_W-1:0] idx);
      return {1'b0, idx};
   endfunction

endpackage

// File: rtl/simple_proc_ctrl_if.sv
// rtl/simple_proc_ctrl_if.sv - control/datapath signal bundle for simple_proc_ctrl
//
// Purpose: groups the run/instruction inputs and all datapath control outputs.
// Signal names carry the control unit's direction (i_ into it, o_ out of it).
// Modports:
//   master - the datapath/sequencer driver side: drives i_run, i_din; reads controls
//   slave  - the control unit: reads i_run, i_din; drives controls
//   i_run     1  start request
//   i_din     9  instruction word / immediate data
//   o_ir_en   1  instruction register load
//   o_r_en    8  one-hot R0..R7 load enables
//   o_a_en    1  A load enable
//   o_g_en    1  G load enable
//   o_bus_sel 4  bus source select
//   o_addsub  1  0 = add, 1 = subtract
//   o_done    1  completion pulse

interface simple_proc_ctrl_if;

   logic                                i_run;
   logic [simple_proc_pkg::IR_W-1:0]    i_din;
   logic                                o_ir_en;
   logic [simple_proc_pkg::NUM_REGS-1:0] o_r_en;
   logic                                o_a_en;
   logic                                o_g_en;
   logic [simple_proc_pkg::SEL_W-1:0]   o_bus_sel;
   logic                                o_addsub;
   logic                                o_done;

   modport master (
      output i_run, i_din,
      input  o_ir_en, o_r_en, o_a_en, o_g_en, o_bus_sel, o_addsub, o_done
   );

   modport slave (
      input  i_run, i_din,
      output o_ir_en, o_r_en, o_a_en, o_g_en, o_bus_sel, o_addsub, o_done
   );

endinterface

// File: rtl/simple_proc_dec3to8.sv
// rtl/simple_proc_dec3to8.sv - 3-to-8 one-hot decoder with enable
//
// Purpose: converts a register index into a one-hot load enable; all zero
// when disabled, so the result is never multi-hot.
// Ports:
//   i_en      1  decoder enable
//   i_idx     3  register index
//   o_onehot  8  one-hot output

module simple_proc_dec3to8
   import simple_proc_pkg::*;
(
   input  logic                i_en,
   input  logic [IDX_W-1:0]    i_idx,
   output logic [NUM_REGS-1:0] o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) begin
         o_onehot[i_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/simple_proc_ctrl.sv
// rtl/simple_proc_ctrl.sv - four-state control sequencer for the simple processor
//
// Purpose: captures a 9-bit instruction in T0 and steps through T1..T3,
// driving register load enables, bus select and add/sub for mv, mvi, add,
// sub and no-op, with a one-cycle done pulse on the last step.
// Ports:
//   i_clk  1  clock, rising edge
//   i_rst  1  asynchronous active-high reset
//   bus       simple_proc_ctrl_if.slave (run/din in, datapath controls out)

module simple_proc_ctrl
   import simple_proc_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   simple_proc_ctrl_if.slave  bus
);

   state_t              r_state;
   state_t              w_next;
   logic [IR_W-1:0]     r_ir;

   logic [2:0]          w_opc;
   logic [IDX_W-1:0]    w_rx;
   logic [IDX_W-1:0]    w_ry;

   logic                w_ir_en;
   logic                w_r_load;
   logic                w_a_en;
   logic                w_g_en;
   logic [SEL_W-1:0]    w_bus_sel;
   logic                w_addsub;
   logic                w_done;

   assign w_opc = r_ir[8:6];
   assign w_rx  = r_ir[5:3];
   assign w_ry  = r_ir[2:0];

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_T0;
      end else begin
         r_state <= w_next;
      end
   end

   // Instruction register; only loads on a T0 capture, so it stays stable until done
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ir <= '0;
      end else if (w_ir_en) begin
         r_ir <= bus.i_din;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_T0: begin
            if (bus.i_run) begin
               w_next = ST_T1;
            end
         end
         ST_T1: begin
            if (w_opc == OPC_ADD || w_opc == OPC_SUB) begin
               w_next = ST_T2;
            end else begin
               w_next = ST_T0;
            end
         end
         ST_T2:   w_next = ST_T3;
         ST_T3:   w_next = ST_T0;
         default: w_next = ST_T0;
      endcase
   end

   // Output logic. Everything is also gated by i_rst so that the outputs sit
   // at their reset values for the whole reset pulse, independent of i_run.
   always_comb begin
      w_ir_en   = 1'b0;
      w_r_load  = 1'b0;
      w_a_en    = 1'b0;
      w_g_en    = 1'b0;
      w_bus_sel = SEL_DIN;
      w_addsub  = 1'b0;
      w_done    = 1'b0;
      if (!i_rst) begin
         case (r_state)
            ST_T0: begin
               w_ir_en = bus.i_run;
            end
            ST_T1: begin
               case (w_opc)
                  OPC_MV: begin
                     w_bus_sel = reg_sel(w_ry);
                     w_r_load  = 1'b1;
                     w_done    = 1'b1;
                  end
                  OPC_MVI: begin
                     w_r_load  = 1'b1;
                     w_done    = 1'b1;
                  end
                  OPC_ADD, OPC_SUB: begin
                     w_bus_sel = reg_sel(w_rx);
                     w_a_en    = 1'b1;
                  end
                  default: begin
                     w_done    = 1'b1;
                  end
               endcase
            end
            ST_T2: begin
               w_bus_sel = reg_sel(w_ry);
               w_g_en    = 1'b1;
               // add/sub differ only in the opcode LSB
               w_addsub  = r_ir[6];
            end
            ST_T3: begin
               w_bus_sel = SEL_G;
               w_r_load  = 1'b1;
               w_done    = 1'b1;
            end
            default: begin
               w_bus_sel = SEL_DIN;
            end
         endcase
      end
   end

   simple_proc_dec3to8 u_rdec (
      .i_en     (w_r_load),
      .i_idx    (w_rx),
      .o_onehot (bus.o_r_en)
   );

   assign bus.o_ir_en   = w_ir_en;
   assign bus.o_a_en    = w_a_en;
   assign bus.o_g_en    = w_g_en;
   assign bus.o_bus_sel = w_bus_sel;
   assign bus.o_addsub  = w_addsub;
   assign bus.o_done    = w_done;

endmodule
